alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
- REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
- REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
- REQ-004 SHALL have port in_valid  input  1  request present on A, B, ALU_FUN.
- REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
- REQ-006 SHALL have port A  input  WIDTH  first operand, unsigned.
- REQ-007 SHALL have port B  input  WIDTH  second operand, unsigned.
- REQ-008 SHALL have port ALU_FUN  input  4  opcode.
- REQ-009 SHALL have port out_valid  output  1  result and flags valid.
- REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
- REQ-011 SHALL have port ALU_OUT  output  WIDTH  registered result.
- REQ-012 SHALL have ports Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  output  1 each  operation class of current result.
- REQ-013 SHALL have port Carry_Flag  output  1  add carry-out / sub borrow / mul overflow.
- REQ-014 SHALL have port Div0_Flag  output  1  divide with B==0.

Function
- REQ-015 Opcodes SHALL be: 0 A+B, 1 A-B, 2 A*B low WIDTH bits, 3 A/B quotient, 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR, 10 (A==B)?1:0, 11 (A>B)?2:0, 12 (A<B)?3:0, 13 A>>1 logical, 14 A<<1, 15 result 0.
- REQ-016 Flags SHALL be: Arith for 0-3, Logic for 4-9, CMP for 10-12 regardless of compare outcome, Shift for 13-14, none for 15; at most one class flag high.
- REQ-017 Carry_Flag SHALL be carry-out of add, borrow (A<B) of sub, (upper WIDTH product bits != 0) of mul, 0 otherwise.
- REQ-018 A request SHALL be accepted on a rising edge where in_valid && in_ready; operands and opcode are captured at that edge.
- REQ-019 in_ready SHALL equal rst_n && (state==IDLE) && (!out_valid || out_ready).
- REQ-020 FSM SHALL have states IDLE and DIV; opcode 3 with B!=0 moves IDLE->DIV, all other accepts stay in IDLE.
- REQ-021 Non-divide opcodes and divide-by-zero SHALL have latency 1: out_valid high in the cycle after acceptance.
- REQ-022 Divide SHALL be iterative restoring, one quotient bit per cycle, WIDTH cycles in DIV, then DIV->IDLE with out_valid high WIDTH+1 cycles after acceptance.
- REQ-023 Divide by zero SHALL give ALU_OUT all-ones, Div0_Flag=1, Arith_Flag=1.
- REQ-024 While out_valid && !out_ready, ALU_OUT, all flags and out_valid SHALL hold stable.
- REQ-025 out_valid SHALL drop on the edge where out_ready is high, unless a new result is loaded on that same edge (throughput 1/cycle for single-cycle ops).
- REQ-026 Inputs SHALL be ignored while in_ready is low; in_valid without acceptance has no effect.
- REQ-027 All outputs except in_ready SHALL be registered.

Reset
- REQ-028 While rst_n low at an edge: state=IDLE, out_valid=0, ALU_OUT=0, all flags 0; in_ready=0 while rst_n is low.
- REQ-029 Reset during DIV SHALL abandon the division with no result produced; first edge with rst_n high returns in_ready=1.

Verification (WIDTH=8)
- REQ-030 Add: A=200, B=100, op 0, out_ready=1 -> next cycle out_valid=1, ALU_OUT=44, Carry=1, Arith=1, others 0.
- REQ-031 Divide: A=200, B=7, op 3 -> in_ready low 8 cycles, out_valid 9 cycles after accept, ALU_OUT=28, Div0=0.
- REQ-032 Divide by zero: A=5, B=0, op 3 -> 1 cycle later ALU_OUT=255, Div0=1, Arith=1.
- REQ-033 Back-pressure: out_ready=0, op 4 A=0xF0 B=0x3C -> ALU_OUT=0x30 held, in_ready=0; second request stalls until out_ready=1, then is accepted the same edge.
- REQ-034 Compare/default: A=5, B=9, op 12 -> ALU_OUT=3, CMP=1; op 11 -> ALU_OUT=0, CMP=1; op 15 -> ALU_OUT=0, all flags 0.
- REQ-035 Reset mid-divide: rst_n low 1 cycle during DIV -> out_valid=0, ALU_OUT=0; following op 1 A=3 B=5 -> ALU_OUT=254, Carry=1.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 16 opcodes, registered result and class/carry/div0 flags.
// Latency 1 for all ops except divide (B!=0), which takes WIDTH+1 cycles.
// Result holds while out_valid && !out_ready; in_ready drops during divide or when the output is stalled.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             Arith_Flag,
    output logic             Logic_Flag,
    output logic             CMP_Flag,
    output logic             Shift_Flag,
    output logic             Carry_Flag,
    output logic             Div0_Flag
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, DIV} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [5:0]       flags_q, flags_d;   // {arith, logic, cmp, shift, carry, div0}

    logic             accept;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] res;
    logic [5:0]       res_flags;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    assign in_ready = rst_n && (state_q == IDLE) && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum       = {1'b0, A} + {1'b0, B};
        prod      = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        res       = '0;
        res_flags = 6'b000000;
        case (ALU_FUN)
            4'd0:  begin res = sum[WIDTH-1:0];  res_flags = {5'b10000, 1'b0} | {4'b0000, sum[WIDTH], 1'b0}; end
            4'd1:  begin res = A - B;           res_flags = 6'b100000 | {4'b0000, (A < B), 1'b0}; end
            4'd2:  begin res = prod[WIDTH-1:0]; res_flags = 6'b100000 | {4'b0000, (|prod[2*WIDTH-1:WIDTH]), 1'b0}; end
            4'd3:  begin res = '1;              res_flags = 6'b100001; end
            4'd4:  begin res = A & B;           res_flags = 6'b010000; end
            4'd5:  begin res = A | B;           res_flags = 6'b010000; end
            4'd6:  begin res = ~(A & B);        res_flags = 6'b010000; end
            4'd7:  begin res = ~(A | B);        res_flags = 6'b010000; end
            4'd8:  begin res = A ^ B;           res_flags = 6'b010000; end
            4'd9:  begin res = ~(A ^ B);        res_flags = 6'b010000; end
            4'd10: begin res = (A == B) ? WIDTH'(1) : '0; res_flags = 6'b001000; end
            4'd11: begin res = (A > B)  ? WIDTH'(2) : '0; res_flags = 6'b001000; end
            4'd12: begin res = (A < B)  ? WIDTH'(3) : '0; res_flags = 6'b001000; end
            4'd13: begin res = A >> 1;          res_flags = 6'b000100; end
            4'd14: begin res = A << 1;          res_flags = 6'b000100; end
            default: begin res = '0;            res_flags = 6'b000000; end
        endcase
    end

    // Restoring divide step: shift the next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, dvs_q};
        q_bit   = !diff[WIDTH];
        rem_nxt = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nxt = {quo_q[WIDTH-2:0], q_bit};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        out_d   = out_q;
        flags_d = flags_q;
        valid_d = valid_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ALU_FUN == 4'd3 && B != '0) begin
                        state_d = DIV;
                        cnt_d   = '0;
                        quo_d   = A;
                        rem_d   = '0;
                        dvs_d   = B;
                    end else begin
                        out_d   = res;
                        flags_d = res_flags;
                        valid_d = 1'b1;
                    end
                end
            end
            DIV: begin
                quo_d = quo_nxt;
                rem_d = rem_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    out_d   = quo_nxt;
                    flags_d = 6'b100000;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            out_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            out_q   <= out_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid  = valid_q;
    assign ALU_OUT    = out_q;
    assign Arith_Flag = flags_q[5];
    assign Logic_Flag = flags_q[4];
    assign CMP_Flag   = flags_q[3];
    assign Shift_Flag = flags_q[2];
    assign Carry_Flag = flags_q[1];
    assign Div0_Flag  = flags_q[0];
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=8): directed scenarios plus randomized ops against an integer-arithmetic model.
// Flag vectors are packed {arith, logic, cmp, shift, carry, div0}.
module tb_alu_mc;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A, B;
    logic [3:0] ALU_FUN;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] ALU_OUT;
    logic       Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, Carry_Flag, Div0_Flag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .out_valid(out_valid), .out_ready(out_ready),
        .ALU_OUT(ALU_OUT), .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
        .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag), .Carry_Flag(Carry_Flag),
        .Div0_Flag(Div0_Flag)
    );

    function automatic logic [5:0] obs_flags();
        return {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, Carry_Flag, Div0_Flag};
    endfunction

    // Reference model from the opcode table using plain integer arithmetic.
    function automatic void model(input int op, input int a, input int b,
                                  output logic [7:0] r, output logic [5:0] f, output int lat);
        int t;
        lat = 1;
        f   = 6'b0;
        r   = 8'd0;
        case (op)
            0:  begin t = a + b; r = 8'(t); f[5] = 1; f[1] = (t > 255); end
            1:  begin t = a - b; r = 8'(t); f[5] = 1; f[1] = (a < b); end
            2:  begin t = a * b; r = 8'(t); f[5] = 1; f[1] = (t > 255); end
            3:  begin
                    f[5] = 1;
                    if (b == 0) begin r = 8'd255; f[0] = 1; end
                    else begin r = 8'(a / b); lat = 9; end
                end
            4:  begin r = 8'(a & b);    f[4] = 1; end
            5:  begin r = 8'(a | b);    f[4] = 1; end
            6:  begin r = ~8'(a & b);   f[4] = 1; end
            7:  begin r = ~8'(a | b);   f[4] = 1; end
            8:  begin r = 8'(a ^ b);    f[4] = 1; end
            9:  begin r = ~8'(a ^ b);   f[4] = 1; end
            10: begin r = (a == b) ? 8'd1 : 8'd0; f[3] = 1; end
            11: begin r = (a > b)  ? 8'd2 : 8'd0; f[3] = 1; end
            12: begin r = (a < b)  ? 8'd3 : 8'd0; f[3] = 1; end
            13: begin r = 8'(a >> 1);  f[2] = 1; end
            14: begin r = 8'(a << 1);  f[2] = 1; end
            default: begin r = 8'd0; end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request with out_ready=1 and report what came back; lat=-1 means timeout.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic [5:0] f, output int lat, output int nlow);
        int w;
        out_ready = 1'b1;
        ALU_FUN = op; A = a; B = b; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin tick(); w++; end
        tick();
        in_valid = 1'b0;
        A = $urandom; B = $urandom; ALU_FUN = 4'($urandom);
        lat = 1; nlow = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) nlow++;
            tick();
            lat++;
        end
        if (!out_valid || w >= 50) lat = -1;
        r = ALU_OUT;
        f = obs_flags();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        A = 8'd200; B = 8'd100; ALU_FUN = 4'd0;
        tick(); tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (ALU_OUT !== 8'd0 || obs_flags() !== 6'b0) begin
            n_fail++; $display("FAIL reset_out got %h/%b want 00/000000", ALU_OUT, obs_flags());
        end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        logic [7:0] r; logic [5:0] f; int lat, nlow;
        run_op(4'd0, 8'd200, 8'd100, r, f, lat, nlow);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL add_latency got %0d want 1", lat); end
        n_checks++;
        if (r !== 8'd44 || f !== 6'b100010) begin
            n_fail++; $display("FAIL add_result got %0d/%b want 44/100010", r, f);
        end
    endtask

    task automatic test_div();
        logic [7:0] r; logic [5:0] f; int lat, nlow;
        run_op(4'd3, 8'd200, 8'd7, r, f, lat, nlow);
        n_checks++;
        if (lat !== 9) begin n_fail++; $display("FAIL div_latency got %0d want 9", lat); end
        n_checks++;
        if (nlow !== 8) begin n_fail++; $display("FAIL div_in_ready_low got %0d want 8", nlow); end
        n_checks++;
        if (r !== 8'd28 || f !== 6'b100000) begin
            n_fail++; $display("FAIL div_result got %0d/%b want 28/100000", r, f);
        end
    endtask

    task automatic test_div0();
        logic [7:0] r; logic [5:0] f; int lat, nlow;
        run_op(4'd3, 8'd5, 8'd0, r, f, lat, nlow);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL div0_latency got %0d want 1", lat); end
        n_checks++;
        if (r !== 8'd255 || f !== 6'b100001) begin
            n_fail++; $display("FAIL div0_result got %0d/%b want 255/100001", r, f);
        end
    endtask

    task automatic test_backpressure();
        tick();
        out_ready = 1'b0;
        ALU_FUN = 4'd4; A = 8'hF0; B = 8'h3C; in_valid = 1'b1;
        tick();
        ALU_FUN = 4'd0; A = 8'd1; B = 8'd2;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || ALU_OUT !== 8'h30 || obs_flags() !== 6'b010000 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc %0d got v=%b out=%h f=%b rdy=%b want v=1 out=30 f=010000 rdy=0",
                         i, out_valid, ALU_OUT, obs_flags(), in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || ALU_OUT !== 8'd3 || obs_flags() !== 6'b100000) begin
            n_fail++; $display("FAIL bp_second got v=%b out=%0d f=%b want v=1 out=3 f=100000",
                               out_valid, ALU_OUT, obs_flags());
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop got %b want 0", out_valid); end
    endtask

    task automatic test_cmp_default();
        logic [7:0] r; logic [5:0] f; int lat, nlow;
        run_op(4'd12, 8'd5, 8'd9, r, f, lat, nlow);
        n_checks++;
        if (r !== 8'd3 || f !== 6'b001000 || lat !== 1) begin
            n_fail++; $display("FAIL cmp_lt got %0d/%b/%0d want 3/001000/1", r, f, lat);
        end
        run_op(4'd11, 8'd5, 8'd9, r, f, lat, nlow);
        n_checks++;
        if (r !== 8'd0 || f !== 6'b001000 || lat !== 1) begin
            n_fail++; $display("FAIL cmp_gt got %0d/%b/%0d want 0/001000/1", r, f, lat);
        end
        run_op(4'd15, 8'd5, 8'd9, r, f, lat, nlow);
        n_checks++;
        if (r !== 8'd0 || f !== 6'b000000 || lat !== 1) begin
            n_fail++; $display("FAIL op15 got %0d/%b/%0d want 0/000000/1", r, f, lat);
        end
    endtask

    task automatic test_reset_mid_div();
        logic [7:0] r; logic [5:0] f; int lat, nlow; int seen;
        out_ready = 1'b1;
        ALU_FUN = 4'd3; A = 8'd200; B = 8'd7; in_valid = 1'b1;
        while (!in_ready) tick();
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || ALU_OUT !== 8'd0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstdiv_state got v=%b out=%0d rdy=%b want 0/0/0", out_valid, ALU_OUT, in_ready);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstdiv_ready got %b want 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL rstdiv_no_result got %0d valid cycles want 0", seen); end
        run_op(4'd1, 8'd3, 8'd5, r, f, lat, nlow);
        n_checks++;
        if (r !== 8'd254 || f !== 6'b100010 || lat !== 1) begin
            n_fail++; $display("FAIL rstdiv_sub got %0d/%b/%0d want 254/100010/1", r, f, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] r, er; logic [5:0] f, ef; int lat, elat, nlow;
        logic [3:0] op; logic [7:0] a, b;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            model(int'(op), int'(a), int'(b), er, ef, elat);
            run_op(op, a, b, r, f, lat, nlow);
            n_checks++;
            if (r !== er || f !== ef || lat !== elat || nlow !== elat - 1) begin
                n_fail++;
                $display("FAIL rand op=%0d a=%0d b=%0d got %0d/%b/lat%0d/low%0d want %0d/%b/lat%0d/low%0d",
                         op, a, b, r, f, lat, nlow, er, ef, elat, elat - 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] er; logic [5:0] ef; int elat;
        logic [3:0] op; logic [7:0] a, b;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = (op == 4'd3) ? 8'd0 : 8'($urandom);
            model(int'(op), int'(a), int'(b), er, ef, elat);
            ALU_FUN = op; A = a; B = b; in_valid = 1'b1;
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || ALU_OUT !== er || obs_flags() !== ef || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b %0d op=%0d a=%0d b=%0d got v=%b %0d/%b rdy=%b want v=1 %0d/%b rdy=1",
                         i, op, a, b, out_valid, ALU_OUT, obs_flags(), in_ready, er, ef);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_div();
        test_div0();
        test_backpressure();
        test_cmp_default();
        test_reset_mid_div();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
